// File: rtl/rgb565_pkg.sv
// Shared types and constants for the RGB565 receive path.
package rgb565_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } seq_state_t;

    typedef logic [15:0] pixel_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int PIXELS_PER_BEAT = 2;

    // Counter width that never collapses to zero bits for tiny geometries.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rgb565.sv
// Combinational RGB565 decoder: unpacks one payload beat into a pixel pair.
module rgb565
    import rgb565_pkg::*;
(
    input  logic [2*PIXELS_PER_BEAT-1:0][7:0] image_data,
    output pixel_t [PIXELS_PER_BEAT-1:0]      rgb
);

    for (genvar p = 0; p < PIXELS_PER_BEAT; p++) begin : g_pix
        rgb565_t px;
        // Little-endian on the wire: low byte carries G[2:0] and B.
        assign px.r = image_data[2*p+1][7:3];
        assign px.g = {image_data[2*p+1][2:0], image_data[2*p][7:5]};
        assign px.b = image_data[2*p][4:0];
        assign rgb[p] = pixel_t'(px);
    end

endmodule

// File: rtl/rgb565_frame_sequencer.sv
// Frame/line sequencer: tags decoded pixel pairs with x/y and flags short/long frames.
// Optional statistics counters are enabled by defining RGB565_SEQ_STATS_EN.
module rgb565_frame_sequencer
    import rgb565_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [2*PIXELS_PER_BEAT-1:0][7:0]     image_data,
    input  logic                                  image_data_enable,
    input  logic                                  frame_start,
    input  logic                                  frame_end,
    output pixel_t [PIXELS_PER_BEAT-1:0]          rgb,
    output logic                                  rgb_enable,
    output logic [clog2_min1(IMAGE_WIDTH)-1:0]    x,
    output logic [clog2_min1(IMAGE_HEIGHT)-1:0]   y,
    output logic                                  frame_active,
    output logic                                  line_done,
    output logic                                  frame_done,
    output logic                                  underrun,
    output logic                                  overrun
`ifdef RGB565_SEQ_STATS_EN
    ,
    output logic [15:0]                           frame_count,
    output logic [15:0]                           error_count
`endif
);

    localparam int XW = clog2_min1(IMAGE_WIDTH);
    localparam int YW = clog2_min1(IMAGE_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - PIXELS_PER_BEAT);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

    if ((IMAGE_WIDTH % 2) != 0 || IMAGE_WIDTH < 2) begin : g_bad_width
        $error("rgb565_frame_sequencer: IMAGE_WIDTH must be even and >= 2");
    end

    seq_state_t state, state_nxt;
    logic [XW-1:0] x_cnt, x_cnt_nxt, x_eff;
    logic [YW-1:0] y_cnt, y_cnt_nxt, y_eff;
    logic          in_frame, beat, last_col, last_pair;
    pixel_t [PIXELS_PER_BEAT-1:0] dec_rgb;

    logic rgb_enable_d, line_done_d, frame_done_d, underrun_d, overrun_d;

    rgb565 u_dec (
        .image_data (image_data),
        .rgb        (dec_rgb)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            state <= state_nxt;
            x_cnt <= x_cnt_nxt;
            y_cnt <= y_cnt_nxt;
        end
    end

    // frame_start takes effect before the same-cycle beat; frame_end after it.
    always_comb begin
        in_frame  = frame_start || (state == ACTIVE);
        x_eff     = frame_start ? '0 : x_cnt;
        y_eff     = frame_start ? '0 : y_cnt;
        beat      = image_data_enable && in_frame;
        last_col  = (x_eff == X_LAST);
        last_pair = beat && last_col && (y_eff == Y_LAST);

        state_nxt = state;
        x_cnt_nxt = x_eff;
        y_cnt_nxt = y_eff;
        if (beat) begin
            if (last_col) begin
                x_cnt_nxt = '0;
                y_cnt_nxt = (y_eff == Y_LAST) ? '0 : y_eff + 1'b1;
            end else begin
                x_cnt_nxt = x_eff + XW'(PIXELS_PER_BEAT);
            end
        end

        if (frame_start) begin
            state_nxt = last_pair ? DONE : ACTIVE;
        end else begin
            case (state)
                ACTIVE:  state_nxt = frame_end ? IDLE : (last_pair ? DONE : ACTIVE);
                DONE:    state_nxt = frame_end ? IDLE : DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rgb_enable_d = beat;
        line_done_d  = beat && last_col;
        frame_done_d = last_pair;
        underrun_d   = (state == ACTIVE) && (frame_start || (frame_end && !last_pair));
        overrun_d    = (state == DONE) && !frame_start && image_data_enable;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb          <= '0;
            rgb_enable   <= 1'b0;
            x            <= '0;
            y            <= '0;
            frame_active <= 1'b0;
            line_done    <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            rgb_enable   <= rgb_enable_d;
            line_done    <= line_done_d;
            frame_done   <= frame_done_d;
            underrun     <= underrun_d;
            overrun      <= overrun_d;
            frame_active <= (state == ACTIVE);
            if (beat) begin
                rgb <= dec_rgb;
                x   <= x_eff;
                y   <= y_eff;
            end
        end
    end

`ifdef RGB565_SEQ_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            error_count <= '0;
        end else begin
            if (frame_done_d && frame_count != 16'hFFFF)
                frame_count <= frame_count + 16'd1;
            if ((underrun_d || overrun_d) && error_count != 16'hFFFF)
                error_count <= error_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rgb565_frame_sequencer.sv
// Randomized + directed bench for rgb565_frame_sequencer against a pixel-index frame model.
module tb_rgb565_frame_sequencer;

    localparam int W = 4;
    localparam int H = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0][7:0]  image_data = '0;
    logic             image_data_enable = 1'b0;
    logic             frame_start = 1'b0;
    logic             frame_end = 1'b0;
    logic [1:0][15:0] rgb;
    logic             rgb_enable;
    logic [1:0]       x;
    logic [0:0]       y;
    logic             frame_active, line_done, frame_done, underrun, overrun;
`ifdef RGB565_SEQ_STATS_EN
    logic [15:0]      frame_count, error_count;
`endif

    rgb565_frame_sequencer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clock             (clock),
        .reset             (reset),
        .image_data        (image_data),
        .image_data_enable (image_data_enable),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .rgb               (rgb),
        .rgb_enable        (rgb_enable),
        .x                 (x),
        .y                 (y),
        .frame_active      (frame_active),
        .line_done         (line_done),
        .frame_done        (frame_done),
        .underrun          (underrun),
        .overrun           (overrun)
`ifdef RGB565_SEQ_STATS_EN
        ,
        .frame_count       (frame_count),
        .error_count       (error_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 = no frame, 1 = receiving, 2 = all pixels received.
    int mode = 0;
    int npairs = 0;
    int exp_frames = 0;
    int exp_errs = 0;
    logic        e_en, e_ld, e_fd, e_ur, e_ov, e_fa;
    int          e_x, e_y;
    logic [31:0] e_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic fs, input logic fe, input logic en, input logic [31:0] d);
        int prev;
        prev = mode;
        e_en = 0; e_ld = 0; e_fd = 0; e_ur = 0; e_ov = 0;
        if (fs) begin
            if (mode == 1) e_ur = 1;
            mode = 1;
            npairs = 0;
        end
        if (en) begin
            if (mode == 1) begin
                e_en   = 1;
                e_x    = (2 * npairs) % W;
                e_y    = (2 * npairs) / W;
                e_data = d;
                e_ld   = ((2 * npairs + 2) % W) == 0;
                e_fd   = (2 * npairs + 2) == W * H;
                npairs++;
                if (e_fd) mode = 2;
            end else if (mode == 2) begin
                e_ov = 1;
            end
        end
        if (fe && !fs) begin
            if (mode == 1) begin
                e_ur = 1;
                mode = 0;
            end else if (mode == 2) begin
                mode = 0;
            end
        end
        e_fa = (prev == 1);
        if (e_fd && exp_frames < 65535) exp_frames++;
        if ((e_ur || e_ov) && exp_errs < 65535) exp_errs++;
    endtask

    task automatic compare();
        chk("rgb_enable", 32'(rgb_enable), 32'(e_en));
        chk("line_done", 32'(line_done), 32'(e_ld));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("underrun", 32'(underrun), 32'(e_ur));
        chk("overrun", 32'(overrun), 32'(e_ov));
        chk("frame_active", 32'(frame_active), 32'(e_fa));
        if (e_en) begin
            chk("x", 32'(x), e_x);
            chk("y", 32'(y), e_y);
            chk("rgb", rgb, e_data);
        end
`ifdef RGB565_SEQ_STATS_EN
        chk("frame_count", 32'(frame_count), exp_frames);
        chk("error_count", 32'(error_count), exp_errs);
`endif
    endtask

    task automatic step(input logic fs, input logic fe, input logic en, input logic [31:0] d);
        @(negedge clock);
        frame_start = fs;
        frame_end = fe;
        image_data_enable = en;
        image_data = d;
        model_step(fs, fe, en, d);
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_rgb"}, rgb, 32'h0);
        chk({nm, "_en"}, 32'(rgb_enable), 32'h0);
        chk({nm, "_xy"}, 32'({x, y}), 32'h0);
        chk({nm, "_flags"}, 32'({frame_active, line_done, frame_done, underrun, overrun}), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        frame_start = 0; frame_end = 0; image_data_enable = 0; image_data = '0;
        #1;
        check_zero("reset_async");
        @(posedge clock);
        #1;
        check_zero("reset_held");
        @(negedge clock);
        reset = 1'b0;
        mode = 0; npairs = 0; exp_frames = 0; exp_errs = 0;
    endtask

    int lx[4]  = '{0, 2, 0, 2};
    int ly[4]  = '{0, 0, 1, 1};
    int lld[4] = '{0, 1, 0, 1};
    int lfd[4] = '{0, 0, 0, 1};

    initial begin
        #2;
        check_zero("reset_init");
        do_reset();

        // Nominal frame with literal positions; first beat checks byte order.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, (i == 0) ? 32'h5678_1234 : $urandom);
            chk("nom_x", 32'(x), lx[i]);
            chk("nom_y", 32'(y), ly[i]);
            chk("nom_line_done", 32'(line_done), lld[i]);
            chk("nom_frame_done", 32'(frame_done), lfd[i]);
            if (i == 0) begin
                chk("byte_order_px0", 32'(rgb[0]), 32'h1234);
                chk("byte_order_px1", 32'(rgb[1]), 32'h5678);
            end
        end
        step(0, 1, 0, 0);
        chk("nom_no_underrun", 32'(underrun), 32'h0);

        // Short frame, then a frame starting with a same-cycle beat and ending with frame_end on the last beat.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom);
        step(0, 1, 0, 0);
        chk("short_underrun", 32'(underrun), 32'h1);
        step(0, 0, 0, 0);
        chk("short_idle", 32'(frame_active), 32'h0);
        step(1, 0, 1, $urandom);
        chk("fs_beat_en", 32'(rgb_enable), 32'h1);
        chk("fs_beat_xy", 32'({x, y}), 32'h0);
        step(0, 0, 1, $urandom);
        step(0, 0, 1, $urandom);
        step(0, 1, 1, $urandom);
        chk("end_with_last_fd", 32'(frame_done), 32'h1);
        chk("end_with_last_ur", 32'(underrun), 32'h0);

        // Long frame: fifth beat is an overrun and produces no pair.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, $urandom);
        chk("long_overrun", 32'(overrun), 32'h1);
        chk("long_no_pair", 32'(rgb_enable), 32'h0);
        step(0, 1, 0, 0);

        // Restart while active.
        step(1, 0, 0, 0);
        step(0, 0, 1, $urandom);
        step(0, 0, 1, $urandom);
        step(1, 0, 1, $urandom);
        chk("restart_underrun", 32'(underrun), 32'h1);
        chk("restart_xy", 32'({x, y}), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, $urandom);
        step(0, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 75, $urandom);
        end

        // Reset mid-frame, then one clean frame.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 1, $urandom);
        step(0, 0, 1, $urandom);
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, $urandom);
        chk("post_reset_fd", 32'(frame_done), 32'h1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
`ifdef RGB565_SEQ_STATS_EN
        chk("stats_frames", 32'(frame_count), 32'h1);
        chk("stats_errors", 32'(error_count), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
